arf_sequencer: RTL
==================

Name: arf_sequencer

Overview:
- Multi-cycle controller that drives the control inputs of the address register file (PC, AR, SP) and the byte-wide memory strobes.
- Accepts one command at a time over a valid/ready handshake and sequences instruction fetch (PC), stack push/pop (SP) and direct loads/clears.
- Sits between the instruction-decode FSM and the address register file.
- OutDSel drives the memory address mux.

Parameters:
- INIT_CLEAR, 1, when 1 the first cycle after Reset deasserts clears PC/AR/SP.
- FS_DEC, 3'b000, register FunSel code for Q-1.
- FS_INC, 3'b001, register FunSel code for Q+1.
- FS_LOAD, 3'b010, register FunSel code for Q=I.
- FS_CLR, 3'b011, register FunSel code for Q=0.

Ports:
- Clock  in  1  system clock, rising edge
- Reset  in  1  synchronous, active-high
- CmdValid  in  1  command offered
- Cmd  in  3  000 NOP, 001 FETCH, 010 PUSH, 011 POP, 100 JUMP(PC=I), 101 LDAR(AR=I), 110 LDSP(SP=I), 111 CLRALL
- CmdReady  out  1  high only in IDLE
- MemWait  in  1  memory not ready; stalls memory steps
- ARF_FunSel  out  3  to register file FunSel
- ARF_RegSel  out  3  active-low enables; bit2 PC, bit1 AR, bit0 SP
- ARF_OutCSel  out  2  fixed 2'b00 (PC) except LDAR/JUMP: 2'b10
- ARF_OutDSel  out  2  memory address source: 00 PC, 10 AR, 11 SP
- MemRead  out  1  byte read strobe
- MemWrite  out  1  byte write strobe
- ByteSel  out  1  0 low byte, 1 high byte of IR/data
- Busy  out  1  not IDLE
- Done  out  1  one-cycle pulse in final step of a command

Behaviour:
- Idle outputs: RegSel 3'b111, FunSel FS_DEC, OutCSel 00, OutDSel 00, MemRead 0, MemWrite 0, ByteSel 0, Done 0, Busy 0.
- Reset=1 forces idle outputs combinationally in the same cycle; no ARF write may occur.
- Reset=1 drives the state to INIT (INIT_CLEAR=1) or IDLE (INIT_CLEAR=0) at the next edge.
- Reset is valid mid-command; the partial command is abandoned.
- INIT: RegSel 000, FunSel FS_CLR, CmdReady 0, Busy 1, no Done; then IDLE.
- Accept: CmdValid&CmdReady at an edge; Cmd is latched; the first step executes the following cycle.
- NOP is accepted and leaves the block in IDLE with no Done.
- Memory steps (MemRead/MemWrite high) hold while MemWait=1:
  - strobes stay asserted;
  - RegSel forced 111 (no pointer update);
  - the state does not advance.
- FETCH (2 steps):
  - F0: OutDSel 00, MemRead, ByteSel 0, RegSel 011, FunSel FS_INC.
  - F1: same with ByteSel 1, Done.
- PUSH (2 steps, SP points to next free byte, descending):
  - P0: OutDSel 11, MemWrite, ByteSel 1, RegSel 110, FunSel FS_DEC.
  - P1: ByteSel 0, same otherwise, Done.
- POP (3 steps):
  - Q0: RegSel 110, FS_INC, no strobe.
  - Q1: OutDSel 11, MemRead, ByteSel 0, RegSel 110, FS_INC.
  - Q2: OutDSel 11, MemRead, ByteSel 1, RegSel 111, Done.
- JUMP, LDAR, LDSP (1 step each): FunSel FS_LOAD, RegSel 011/101/110 respectively, Done.
- CLRALL (1 step): RegSel 000, FS_CLR, Done.
- Latency from accept to Done (no stall): FETCH 2, PUSH 2, POP 3, others 1. Done is followed by IDLE; back-to-back commands have a 1-cycle IDLE gap.
- Only one RegSel bit is low per step except CLRALL/INIT.
- Pointer wrap-around is a register-file property: SP=0000 PUSH gives FFFF, then FFFE.
- A CmdValid held while Busy is ignored; Cmd changes while Busy have no effect.

Test Plan:
- Reset released with INIT_CLEAR=1 -> one cycle RegSel 000/FunSel 011, then CmdReady=1; PC=AR=SP=0000.
- LDSP with I=0100, then PUSH -> writes at addresses 0100 (high byte) then 00FF (low byte); SP=00FE; Done in the 2nd step cycle.
- POP from SP=00FE -> reads at 00FF (low) and 0100 (high); SP=0100; Done at cycle 3.
- FETCH from PC=0020 with MemWait high 3 cycles in F0 -> address 0020 held, PC not incremented during the stall; final PC=0022, Done 5 cycles after accept.
- Reset asserted in P0 of a PUSH with SP=0010 -> RegSel 111 that cycle; SP stays 0010; state INIT then IDLE.
- PUSH with SP=0000 -> SP=FFFE; CmdValid with a different Cmd while Busy -> ignored, CmdReady 0.

Source files
------------

// File: rtl/arf_sequencer_if.sv
// Handshake and control bundle between the decode FSM, the arf_sequencer,
// the address register file and the byte-wide memory port.
interface arf_sequencer_if;
    logic       cmd_valid;
    logic [2:0] cmd;
    logic       cmd_ready;
    logic       mem_wait;
    logic [2:0] arf_funsel;
    logic [2:0] arf_regsel;
    logic [1:0] arf_outcsel;
    logic [1:0] arf_outdsel;
    logic       mem_read;
    logic       mem_write;
    logic       byte_sel;
    logic       busy;
    logic       done;

    modport slave (
        input  cmd_valid, cmd, mem_wait,
        output cmd_ready, arf_funsel, arf_regsel, arf_outcsel, arf_outdsel,
               mem_read, mem_write, byte_sel, busy, done
    );

    modport master (
        output cmd_valid, cmd, mem_wait,
        input  cmd_ready, arf_funsel, arf_regsel, arf_outcsel, arf_outdsel,
               mem_read, mem_write, byte_sel, busy, done
    );
endinterface

// File: rtl/arf_sequencer.sv
// Multi-cycle controller driving PC/AR/SP control and memory byte strobes
// for fetch, stack push/pop, direct loads and clears.
module arf_sequencer #(
    parameter logic       INIT_CLEAR = 1'b1,
    parameter logic [2:0] FS_DEC     = 3'b000,
    parameter logic [2:0] FS_INC     = 3'b001,
    parameter logic [2:0] FS_LOAD    = 3'b010,
    parameter logic [2:0] FS_CLR     = 3'b011
) (
    input  logic          clock,
    input  logic          reset,
    arf_sequencer_if.slave bus
);
    localparam logic [3:0] ST_IDLE = 4'd0;
    localparam logic [3:0] ST_INIT = 4'd1;
    localparam logic [3:0] ST_F0   = 4'd2;
    localparam logic [3:0] ST_F1   = 4'd3;
    localparam logic [3:0] ST_P0   = 4'd4;
    localparam logic [3:0] ST_P1   = 4'd5;
    localparam logic [3:0] ST_Q0   = 4'd6;
    localparam logic [3:0] ST_Q1   = 4'd7;
    localparam logic [3:0] ST_Q2   = 4'd8;
    localparam logic [3:0] ST_JUMP = 4'd9;
    localparam logic [3:0] ST_LDAR = 4'd10;
    localparam logic [3:0] ST_LDSP = 4'd11;
    localparam logic [3:0] ST_CLR  = 4'd12;

    logic [3:0] state_r;
    logic [3:0] state_s;
    logic [2:0] funsel_s;
    logic [2:0] regsel_s;
    logic [1:0] outcsel_s;
    logic [1:0] outdsel_s;
    logic       rd_s;
    logic       wr_s;
    logic       bsel_s;
    logic       last_s;
    logic       stall_s;

    // State register; reset lands in INIT or IDLE depending on INIT_CLEAR
    always_ff @(posedge clock) begin
        if (reset) begin
            if (INIT_CLEAR) begin
                state_r <= ST_INIT;
            end else begin
                state_r <= ST_IDLE;
            end
        end else begin
            state_r <= state_s;
        end
    end

    // Per-step control word before stall and reset overrides
    always_comb begin
        funsel_s  = FS_DEC;
        regsel_s  = 3'b111;
        outcsel_s = 2'b00;
        outdsel_s = 2'b00;
        rd_s      = 1'b0;
        wr_s      = 1'b0;
        bsel_s    = 1'b0;
        last_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                regsel_s = 3'b111;
            end
            ST_INIT: begin
                regsel_s = 3'b000;
                funsel_s = FS_CLR;
            end
            ST_F0, ST_F1: begin
                rd_s     = 1'b1;
                regsel_s = 3'b011;
                funsel_s = FS_INC;
                bsel_s   = (state_r == ST_F1);
                last_s   = (state_r == ST_F1);
            end
            // SP points at the next free byte: write high byte first, then low
            ST_P0, ST_P1: begin
                outdsel_s = 2'b11;
                wr_s      = 1'b1;
                regsel_s  = 3'b110;
                funsel_s  = FS_DEC;
                bsel_s    = (state_r == ST_P0);
                last_s    = (state_r == ST_P1);
            end
            ST_Q0: begin
                regsel_s = 3'b110;
                funsel_s = FS_INC;
            end
            ST_Q1: begin
                outdsel_s = 2'b11;
                rd_s      = 1'b1;
                regsel_s  = 3'b110;
                funsel_s  = FS_INC;
            end
            ST_Q2: begin
                outdsel_s = 2'b11;
                rd_s      = 1'b1;
                bsel_s    = 1'b1;
                funsel_s  = FS_INC;
                last_s    = 1'b1;
            end
            ST_JUMP: begin
                funsel_s  = FS_LOAD;
                regsel_s  = 3'b011;
                outcsel_s = 2'b10;
                last_s    = 1'b1;
            end
            ST_LDAR: begin
                funsel_s  = FS_LOAD;
                regsel_s  = 3'b101;
                outcsel_s = 2'b10;
                last_s    = 1'b1;
            end
            ST_LDSP: begin
                funsel_s = FS_LOAD;
                regsel_s = 3'b110;
                last_s   = 1'b1;
            end
            ST_CLR: begin
                funsel_s = FS_CLR;
                regsel_s = 3'b000;
                last_s   = 1'b1;
            end
            default: begin
                regsel_s = 3'b111;
            end
        endcase
    end

    assign stall_s = (rd_s | wr_s) & bus.mem_wait;

    // Next-state: memory steps hold while the memory is not ready
    always_comb begin
        state_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    case (bus.cmd)
                        3'b001:  state_s = ST_F0;
                        3'b010:  state_s = ST_P0;
                        3'b011:  state_s = ST_Q0;
                        3'b100:  state_s = ST_JUMP;
                        3'b101:  state_s = ST_LDAR;
                        3'b110:  state_s = ST_LDSP;
                        3'b111:  state_s = ST_CLR;
                        default: state_s = ST_IDLE;
                    endcase
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_F0:   state_s = stall_s ? ST_F0 : ST_F1;
            ST_F1:   state_s = stall_s ? ST_F1 : ST_IDLE;
            ST_P0:   state_s = stall_s ? ST_P0 : ST_P1;
            ST_P1:   state_s = stall_s ? ST_P1 : ST_IDLE;
            ST_Q0:   state_s = ST_Q1;
            ST_Q1:   state_s = stall_s ? ST_Q1 : ST_Q2;
            ST_Q2:   state_s = stall_s ? ST_Q2 : ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Output stage: reset forces idle outputs in the same cycle
    always_comb begin
        if (reset) begin
            bus.arf_funsel  = FS_DEC;
            bus.arf_regsel  = 3'b111;
            bus.arf_outcsel = 2'b00;
            bus.arf_outdsel = 2'b00;
            bus.mem_read    = 1'b0;
            bus.mem_write   = 1'b0;
            bus.byte_sel    = 1'b0;
            bus.done        = 1'b0;
            bus.busy        = 1'b0;
            bus.cmd_ready   = 1'b0;
        end else begin
            bus.arf_funsel  = funsel_s;
            bus.arf_regsel  = stall_s ? 3'b111 : regsel_s;
            bus.arf_outcsel = outcsel_s;
            bus.arf_outdsel = outdsel_s;
            bus.mem_read    = rd_s;
            bus.mem_write   = wr_s;
            bus.byte_sel    = bsel_s;
            bus.done        = last_s & ~stall_s;
            bus.busy        = (state_r != ST_IDLE);
            bus.cmd_ready   = (state_r == ST_IDLE);
        end
    end
endmodule
